// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a 1-entry holding register and valid/ready input.
// Define UART_TX_PARITY_EN to add the parity_odd port and a parity bit after the data bits.
module uart_tx_param #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);
    localparam int CNT_W = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state;
    state_t               state_n;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_n;
    logic [DATA_BITS-1:0] hold;
    logic                 hold_full;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_n;
    logic                 stop_cnt;
    logic                 stop_cnt_n;
    logic                 load;
    logic                 accept;
    logic                 tx_n;
    logic                 done_n;
`ifdef UART_TX_PARITY_EN
    logic                 hold_odd;
    logic                 par_bit;
`endif

    // Handshake: a word transfers on any clk edge where tx_valid & tx_ready; tx_ready
    // means the holding register is empty and is forced low while reset is asserted.
    assign tx_ready = ~rst_n & ~hold_full;
    assign accept   = tx_valid & tx_ready;
    assign busy     = (state != IDLE) | hold_full;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= IDLE;
            shift     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            tx        <= 1'b1;
            done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            hold_odd  <= 1'b0;
            par_bit   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            tx       <= tx_n;
            done     <= done_n;
            if (accept) begin
                hold <= tx_data;
`ifdef UART_TX_PARITY_EN
                hold_odd <= parity_odd;
`endif
            end
            // A transfer in the same cycle as a load refills the register it just freed.
            if (accept) begin
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
`ifdef UART_TX_PARITY_EN
            if (load) begin
                par_bit <= (^hold) ^ hold_odd;
            end
`endif
        end
    end

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        load       = 1'b0;
        done_n     = 1'b0;
        if (baud_tick) begin
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        load    = 1'b1;
                        state_n = START;
                    end
                end
                START: begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
                DATA: begin
                    if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                        stop_cnt_n = 1'b0;
                    end else begin
                        shift_n   = shift >> 1;
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    state_n    = STOP;
                    stop_cnt_n = 1'b0;
                end
`endif
                STOP: begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        done_n = 1'b1;
                        // Chain straight into the next start bit when a word is waiting.
                        if (hold_full) begin
                            load    = 1'b1;
                            state_n = START;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        stop_cnt_n = stop_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        if (load) begin
            shift_n = hold;
        end
    end

    // Line level is decoded from the next state so the registered tx moves with the FSM.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:  tx_n = 1'b0;
            DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_n = par_bit;
`endif
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: an 8N1 instance (a) and a 5-bit, 2-stop instance (b)
// share one clock, reset and a baud tick every 16 clk.
module tb_uart_tx_param;
    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       baud_tick = 1'b0;
    logic       a_valid   = 1'b0;
    logic [7:0] a_data    = '0;
    logic       a_ready, a_tx, a_busy, a_done;
    logic       b_valid   = 1'b0;
    logic [4:0] b_data    = '0;
    logic       b_ready, b_tx, b_busy, b_done;
`ifdef UART_TX_PARITY_EN
    logic       parity_odd = 1'b0;
`endif

    int tests      = 0;
    int fails      = 0;
    int tick_div   = 0;
    int since_tick = 0;
    int a_done_cnt = 0;
    int b_done_cnt = 0;
    int b_hs_cnt   = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_tick (baud_tick),
        .tx_valid  (a_valid),
        .tx_data   (a_data),
        .tx_ready  (a_ready),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .tx        (a_tx),
        .busy      (a_busy),
        .done      (a_done)
    );

    uart_tx_param #(.DATA_BITS(5), .STOP_BITS(2)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_tick (baud_tick),
        .tx_valid  (b_valid),
        .tx_data   (b_data),
        .tx_ready  (b_ready),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .tx        (b_tx),
        .busy      (b_busy),
        .done      (b_done)
    );

    // Baud tick: high for one clk out of every 16.
    always @(negedge clk) begin
        tick_div  = tick_div + 1;
        baud_tick = ((tick_div % 16) == 0);
    end

    always @(posedge clk) begin
        if (baud_tick) since_tick = 0;
        else since_tick = since_tick + 1;
        if (b_valid && b_ready) b_hs_cnt = b_hs_cnt + 1;
    end

    always @(negedge clk) begin
        if (a_done === 1'b1) a_done_cnt = a_done_cnt + 1;
        if (b_done === 1'b1) b_done_cnt = b_done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_tx(input bit sel_b);
        return sel_b ? b_tx : a_tx;
    endfunction

    // Waits for the start-bit edge and checks it came 1 clk after a baud tick.
    task automatic wait_start(input bit sel_b, input int bound, input string tag);
        int n = 0;
        while (cur_tx(sel_b) !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({tag, " start_found"}, cur_tx(sel_b), 0);
        check({tag, " start_phase"}, since_tick, 0);
    endtask

    // Samples every bit of a frame near its middle; ends at the last stop-bit sample.
    task automatic watch_frame(input bit sel_b, input logic [8:0] data, input int bound,
                               input bit offer, input logic [7:0] offer_data, input string tag);
        int nbits = sel_b ? 5 : 8;
        int nstop = sel_b ? 2 : 1;
        wait_start(sel_b, bound, tag);
        repeat (8) @(negedge clk);
        check({tag, " start_bit"}, cur_tx(sel_b), 0);
        for (int i = 0; i < nbits; i++) begin
            repeat (16) @(negedge clk);
            check($sformatf("%s data_bit%0d", tag, i), cur_tx(sel_b), data[i]);
            if (offer && i == 1) begin
                check({tag, " ready_before_offer"}, a_ready, 1);
                a_valid = 1'b1;
                a_data  = offer_data;
                @(negedge clk);
                a_valid = 1'b0;
                check({tag, " ready_after_offer"}, a_ready, 0);
            end
        end
`ifdef UART_TX_PARITY_EN
        repeat (16) @(negedge clk);
        check({tag, " parity_bit"}, cur_tx(sel_b), (^data) ^ parity_odd);
`endif
        for (int s = 0; s < nstop; s++) begin
            repeat (16) @(negedge clk);
            check($sformatf("%s stop_bit%0d", tag, s), cur_tx(sel_b), 1);
        end
    endtask

    task automatic finish_frame(input bit sel_b, input logic exp_busy, input string tag);
        int   n = 0;
        logic d;
        d = sel_b ? b_done : a_done;
        while (d !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            d = sel_b ? b_done : a_done;
        end
        check({tag, " done_seen"}, d, 1);
        check({tag, " busy_at_done"}, sel_b ? b_busy : a_busy, exp_busy);
    endtask

    initial begin
        // Reset held for two edges, then released.
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst a_tx", a_tx, 1);
        check("rst a_busy", a_busy, 0);
        check("rst a_done", a_done, 0);
        check("rst a_ready", a_ready, 0);
        check("rst b_tx", b_tx, 1);
        check("rst b_ready", b_ready, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rel a_ready", a_ready, 1);
        check("rel b_ready", b_ready, 1);
        check("rel a_busy", a_busy, 0);

        // Single 0xA5 frame: 0,1,0,1,0,0,1,0,1,1.
        a_data  = 8'hA5;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        check("sf ready_after_accept", a_ready, 0);
        check("sf busy_after_accept", a_busy, 1);
        watch_frame(1'b0, 9'h0A5, 40, 1'b0, 8'h00, "sf");
        finish_frame(1'b0, 1'b0, "sf");
        @(negedge clk);
        check("sf done_width", a_done, 0);
        check("sf idle_tx", a_tx, 1);
        check("sf done_count", a_done_cnt, 1);

        // Back-to-back: 0x00 then 0xFF offered during its data bits.
        a_data  = 8'h00;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        watch_frame(1'b0, 9'h000, 40, 1'b1, 8'hFF, "b2b0");
        check("b2b0 ready_in_stop", a_ready, 0);
        watch_frame(1'b0, 9'h0FF, 10, 1'b0, 8'h00, "b2b1");
        finish_frame(1'b0, 1'b0, "b2b1");
        @(negedge clk);
        check("b2b done_width", a_done, 0);
        check("b2b done_count", a_done_cnt, 3);

        // Reset in the middle of data bit 3 of 0xC3 (bit 3 is 0).
        a_data  = 8'hC3;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        wait_start(1'b0, 40, "rmid");
        repeat (8 + 16 * 4) @(negedge clk);
        check("rmid bit3_low", a_tx, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rmid tx_high", a_tx, 1);
        check("rmid busy", a_busy, 0);
        check("rmid done", a_done, 0);
        check("rmid ready_in_reset", a_ready, 0);
        rst_n = 1'b0;
        repeat (40) @(negedge clk);
        check("rmid line_idle", a_tx, 1);
        check("rmid busy_idle", a_busy, 0);
        check("rmid no_done", a_done_cnt, 3);
        a_data  = 8'h5A;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        watch_frame(1'b0, 9'h05A, 40, 1'b0, 8'h00, "rpost");
        finish_frame(1'b0, 1'b0, "rpost");
        @(negedge clk);
        check("rpost done_count", a_done_cnt, 4);

        // Backpressure on the 5-bit, 2-stop instance: tx_valid held with 0x1F.
        b_data  = 5'h1F;
        b_valid = 1'b1;
        watch_frame(1'b1, 9'h01F, 40, 1'b0, 8'h00, "bp0");
        finish_frame(1'b1, 1'b1, "bp0");
        b_valid = 1'b0;
        check("bp0 ready_at_reload", b_ready, 1);
        watch_frame(1'b1, 9'h01F, 10, 1'b0, 8'h00, "bp1");
        finish_frame(1'b1, 1'b0, "bp1");
        @(negedge clk);
        check("bp hs_count", b_hs_cnt, 2);
        check("bp done_count", b_done_cnt, 2);
        check("bp ready_idle", b_ready, 1);
        check("bp busy_idle", b_busy, 0);

`ifdef UART_TX_PARITY_EN
        // 0x07 with even parity gives parity bit 1, with odd parity gives 0.
        parity_odd = 1'b0;
        b_data     = 5'h07;
        b_valid    = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        watch_frame(1'b1, 9'h007, 40, 1'b0, 8'h00, "par_even");
        finish_frame(1'b1, 1'b0, "par_even");
        parity_odd = 1'b1;
        b_valid    = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        watch_frame(1'b1, 9'h007, 40, 1'b0, 8'h00, "par_odd");
        finish_frame(1'b1, 1'b0, "par_odd");
        @(negedge clk);
        check("par done_count", b_done_cnt, 4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
